riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the core's MEM-stage data port (addr, store data, rd/wr enables). It converts each MEM-stage access into a single word-aligned bus transaction with a req/ack handshake and byte enables. It formats load data by size and sign, and holds the pipeline via stall_o until the transaction completes. Misaligned or illegal accesses are rejected without touching the bus.

Parameters:
DW, 32, data/address width (fixed by `dw)
TIMEOUT, 255, maximum BUSY cycles without ack before a forced fault (1..65535)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
addr_i  in  DW  byte address from MEM stage (ALU result)
wdata_i  in  DW  store data (rs2)
rd_en_i  in  1  load request
wr_en_i  in  1  store request
funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rdata_o  out  DW  formatted load result, valid in DONE
stall_o  out  1  hold PC and all pipeline registers up to MEM/WB
fault_o  out  1  one-cycle pulse: misaligned, illegal, bus error or timeout
bus_req_o  out  1  transaction request
bus_we_o  out  1  1 = write
bus_addr_o  out  DW  word address, {addr[DW-1:2],2'b00}
bus_wdata_o  out  DW  lane-replicated store data
bus_be_o  out  4  byte enables
bus_ack_i  in  1  transaction complete
bus_rdata_i  in  DW  read data, valid with ack
bus_err_i  in  1  bus error, valid with ack

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, timeout counter=0. All registered outputs (rdata_o, fault_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o) go to 0.
- Reset mid-transaction: bus_req_o drops at the next edge and the transaction is abandoned. A late ack arriving in IDLE is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request (rd_en_i=wr_en_i=0): stall_o=0, remain in IDLE.
- IDLE, legal request: stall_o=1 combinationally.
  - Next edge: register the bus_* outputs, bus_req_o=1, go to BUSY, counter=0.
- IDLE, illegal request: stall_o=0, no bus activity, and at the next edge fault_o=1 for one cycle, rdata_o=0, stay IDLE. A request is illegal if any of the following holds:
  - rd_en_i and wr_en_i both high;
  - funct3 is 011, 110 or 111, or is 1xx on a store;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
- BUSY: stall_o=1 and bus_* outputs held stable.
  - On bus_ack_i: bus_req_o=0 and go to DONE. Load data is formatted into rdata_o (0 for stores). fault_o pulses if bus_err_i, and rdata_o=0 on error.
  - Counter reaching TIMEOUT without ack: same exit with fault_o pulse and rdata_o=0.
  - Otherwise counter increments.
- DONE: stall_o=0 for exactly one cycle, rdata_o valid, and the pipeline advances. Next edge returns to IDLE.
  - DONE never starts a new access, even though the MEM-stage inputs still show the completed request this cycle.
- Latency: ack in the first BUSY cycle gives 2 stall cycles; each extra ack wait cycle adds 1.
- Byte enables: B/BU = 4'b0001<<addr[1:0]; H/HU = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
- Store data replication: B = {4{wdata_i[7:0]}}; H = {2{wdata_i[15:0]}}; W = wdata_i.
- Load formatting: shift = bus_rdata_i >> (8*addr[1:0]).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes unchanged.
- rdata_o holds its value outside DONE until the next completion or fault.

Decomposition:
- define.h additions: funct3 size codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and FSM state encodings.
- One combinational sub-module, riscv_lsu_align: inputs addr[1:0], funct3, wdata, rdata; outputs be, replicated wdata, formatted rdata, misaligned/illegal flag.
- riscv_lsu contains only the FSM, the timeout counter and the output registers.

Test Plan:
- LW addr=0x100, ack on the first BUSY cycle with rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall_o high for 2 cycles, rdata_o=0xDEADBEEF in DONE, fault_o=0.
- LB addr=0x103, rdata=0x80xxxxxx -> be=1000, rdata_o=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles -> bus_we=1, bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD, stall_o high for 5 cycles.
- LW addr=0x101 -> no bus_req, stall_o=0, fault_o pulse, rdata_o=0; same result with rd_en_i and wr_en_i both high, and for funct3=011.
- TIMEOUT=4, LW with no ack -> stall_o high for 6 cycles (IDLE + 5 BUSY), then DONE with fault_o=1, rdata_o=0; an ack with bus_err_i=1 gives the same fault.
- rst_i asserted during BUSY -> next cycle bus_req_o=0, state IDLE; a stray ack afterwards causes no output change.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Access size codes (funct3) and FSM state encodings.
package riscv_lsu_pkg;

    localparam int LSU_DW = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: enables, store replication,
// load extraction/extension and legality of the access.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_funct3,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [LSU_DW-1:0] i_wdata,
    input  logic [LSU_DW-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [LSU_DW-1:0] o_wdata,
    output logic [LSU_DW-1:0] o_rdata,
    output logic              o_illegal
);

    logic [LSU_DW-1:0] w_shift;
    logic              w_bad;

    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = '0;
        w_bad   = 1'b0;
        case (i_funct3)
            LSU_B, LSU_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shift[7] & ~i_funct3[2]}}, w_shift[7:0]};
            end
            LSU_H, LSU_HU: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shift[15] & ~i_funct3[2]}}, w_shift[15:0]};
                w_bad   = i_off[0];
            end
            LSU_W: begin
                o_be    = 4'b1111;
                o_rdata = i_rdata;
                w_bad   = |i_off;
            end
            default: w_bad = 1'b1;
        endcase
    end

    // unsigned sizes only make sense for loads
    assign o_illegal = w_bad | (i_rd & i_wr) | (i_wr & i_funct3[2]);

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: one word-aligned req/ack bus
// transaction per access, pipeline stall while it is in flight.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_en_i,
    input  logic          wr_en_i,
    input  logic [2:0]    funct3_i,
    output logic [DW-1:0] rdata_o,
    output logic          stall_o,
    output logic          fault_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [DW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic [3:0]    bus_be_o,
    input  logic          bus_ack_i,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_err_i
);

    localparam logic [15:0] LP_TO = 16'(TIMEOUT);

    lsu_state_e  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;

    logic          w_req;
    logic          w_illegal;
    logic          w_idle;
    logic [1:0]    w_off;
    logic [2:0]    w_funct3;
    logic [3:0]    w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = rd_en_i | wr_en_i;

    // in BUSY the lane logic formats the response of the latched access
    assign w_off    = w_idle ? addr_i[1:0] : r_off;
    assign w_funct3 = w_idle ? funct3_i : r_funct3;

    riscv_lsu_align u_align (
        .i_off     (w_off),
        .i_funct3  (w_funct3),
        .i_rd      (rd_en_i),
        .i_wr      (wr_en_i),
        .i_wdata   (wdata_i),
        .i_rdata   (bus_rdata_i),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata),
        .o_illegal (w_illegal)
    );

    assign stall_o = (r_state == ST_BUSY)
                   | (w_idle & w_req & ~w_illegal);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            rdata_o     <= '0;
            fault_o     <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
        end else begin
            fault_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_illegal) begin
                        fault_o <= 1'b1;
                        rdata_o <= '0;
                    end else if (w_req) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= wr_en_i;
                        bus_addr_o  <= {addr_i[DW-1:2], 2'b00};
                        bus_wdata_o <= w_wdata;
                        bus_be_o    <= w_be;
                        r_off       <= addr_i[1:0];
                        r_funct3    <= funct3_i;
                        r_cnt       <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i || r_cnt == LP_TO) begin
                        bus_req_o <= 1'b0;
                        r_state   <= ST_DONE;
                        if (bus_ack_i && !bus_err_i) begin
                            rdata_o <= bus_we_o ? '0 : w_rdata;
                        end else begin
                            fault_o <= 1'b1;
                            rdata_o <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
